online_adder_lanes: RTL

Parametrised, multi-lane successor to the single-lane radix-2 signed-digit online adder. It adds LANES independent pairs of MSD-first signed-digit operand streams of DIGITS digits each. Online delay is 2, and the block flushes the pipeline automatically at frame end. It sits between serial signed-digit producers and downstream online operators (multipliers, accumulators). All lanes share one frame controller with a valid/ready handshake.

---
 rtl/online_pkg.sv | 39 +++
 rtl/online_add_digit.sv | 72 +++++++
 rtl/online_adder_lanes.sv | 137 +++++++++++++
 3 files changed

// File: rtl/online_pkg.sv
// Shared signed-digit types, digit constants, conversion helpers and the frame FSM state enum
// for the online adder.
package online_pkg;

   typedef logic [1:0] sd_digit_t;   // {p, m}

   localparam sd_digit_t SD_POS  = 2'b10;
   localparam sd_digit_t SD_NEG  = 2'b01;
   localparam sd_digit_t SD_ZERO = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FLUSH
   } state_t;

   // Returned 3 bits wide so two digits can be summed without overflow; 11 decodes as 0.
   function automatic logic signed [2:0] sd_to_int(input sd_digit_t d);
      logic signed [2:0] v;
      case (d)
         SD_POS:  v = 3'sd1;
         SD_NEG:  v = -3'sd1;
         default: v = 3'sd0;
      endcase
      return v;
   endfunction

   function automatic sd_digit_t int_to_sd(input logic signed [2:0] v);
      sd_digit_t d;
      if (v[2])
         d = SD_NEG;
      else if (v != 3'sd0)
         d = SD_POS;
      else
         d = SD_ZERO;
      return d;
   endfunction

endpackage

// File: rtl/online_add_digit.sv
// Per-lane radix-2 signed-digit online addition datapath (online delay 2).
// Holds p_j and w_{j-1}; the incoming digit pair supplies the p_{j+1} lookahead.
module online_add_digit
   import online_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      advance,
   input  logic      flush_zero,
   input  logic      emit,
   input  sd_digit_t x,
   input  sd_digit_t y,
   output sd_digit_t z
);

   logic signed [2:0] p_in;
   logic signed [2:0] p_reg;
   logic signed [2:0] w_reg;
   logic signed [2:0] t_sel;
   logic signed [2:0] w_sel;
   logic signed [2:0] z_sum;
   sd_digit_t         z_reg;

   assign p_in = flush_zero ? 3'sd0 : (sd_to_int(x) + sd_to_int(y));

   always_comb begin
      t_sel = 3'sd0;
      w_sel = 3'sd0;
      case (p_reg)
         3'sd2:  t_sel = 3'sd1;
         -3'sd2: t_sel = -3'sd1;
         3'sd1: begin
            if (!p_in[2]) begin
               t_sel = 3'sd1;
               w_sel = -3'sd1;
            end else begin
               w_sel = 3'sd1;
            end
         end
         -3'sd1: begin
            if (p_in[2] || (p_in == 3'sd0)) begin
               t_sel = -3'sd1;
               w_sel = 3'sd1;
            end else begin
               w_sel = -3'sd1;
            end
         end
         default: ;
      endcase
   end

   // The t/w selection guarantees this sum stays within {-1,0,1}.
   assign z_sum = w_reg + t_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_reg <= 3'sd0;
         w_reg <= 3'sd0;
         z_reg <= SD_ZERO;
      end else begin
         if (advance) begin
            p_reg <= p_in;
            w_reg <= w_sel;
         end
         if (emit)
            z_reg <= int_to_sd(z_sum);
      end
   end

   assign z = z_reg;

endmodule

// File: rtl/online_adder_lanes.sv
// Multi-lane signed-digit online adder: LANES datapaths under one shared frame controller
// that flushes two zero digits at frame end. Optional feature macro: ONLINE_ADD_SUB_EN (per-lane x - y).
module online_adder_lanes
   import online_pkg::*;
#(
   parameter int LANES  = 4,
   parameter int DIGITS = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
`ifdef ONLINE_ADD_SUB_EN
   input  logic [LANES-1:0] sub,
`endif
   input  logic [LANES-1:0] x_p,
   input  logic [LANES-1:0] x_m,
   input  logic [LANES-1:0] y_p,
   input  logic [LANES-1:0] y_m,
   output logic [LANES-1:0] z_p,
   output logic [LANES-1:0] z_m,
   output logic             out_valid,
   output logic             out_first,
   output logic             out_last
);

   localparam int CW = $clog2(DIGITS + 1);

   state_t        state;
   logic [CW-1:0] cnt;
   logic          flush_phase;
   logic          ready_reg;
   logic          accept;
   logic          advance;
   logic          emit;
   logic          flush_zero;

   assign in_ready   = ready_reg;
   assign accept     = in_valid && ready_reg;
   assign flush_zero = (state == ST_FLUSH);
   assign advance    = accept || flush_zero;
   // Digit 1 only primes the lane registers; outputs start with digit 2.
   assign emit       = (accept && (state == ST_RUN)) || flush_zero;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         flush_phase <= 1'b0;
         ready_reg   <= 1'b1;
         out_valid   <= 1'b0;
         out_first   <= 1'b0;
         out_last    <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state <= ST_RUN;
                  cnt   <= CW'(1);
               end
            end
            ST_RUN: begin
               if (accept) begin
                  out_valid <= 1'b1;
                  out_first <= (cnt == CW'(1));
                  cnt       <= cnt + CW'(1);
                  if (cnt == CW'(DIGITS - 1)) begin
                     state       <= ST_FLUSH;
                     ready_reg   <= 1'b0;
                     flush_phase <= 1'b0;
                  end
               end
            end
            ST_FLUSH: begin
               out_valid <= 1'b1;
               if (flush_phase) begin
                  out_last  <= 1'b1;
                  state     <= ST_IDLE;
                  ready_reg <= 1'b1;
                  cnt       <= '0;
               end else begin
                  flush_phase <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               ready_reg <= 1'b1;
            end
         endcase
      end
   end

`ifdef ONLINE_ADD_SUB_EN
   logic [LANES-1:0] sub_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sub_reg <= '0;
      else if (accept && (state == ST_IDLE))
         sub_reg <= sub;
   end
`endif

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      sd_digit_t x_d;
      sd_digit_t y_d;
      sd_digit_t z_d;

      assign x_d = {x_p[gi], x_m[gi]};
`ifdef ONLINE_ADD_SUB_EN
      // Digit 1 uses the live sub bit; the rest of the frame uses the latched copy.
      logic sub_eff;
      assign sub_eff = (state == ST_IDLE) ? sub[gi] : sub_reg[gi];
      assign y_d     = sub_eff ? {y_m[gi], y_p[gi]} : {y_p[gi], y_m[gi]};
`else
      assign y_d = {y_p[gi], y_m[gi]};
`endif

      online_add_digit u_digit (
         .clk        (clk),
         .rst_n      (rst_n),
         .advance    (advance),
         .flush_zero (flush_zero),
         .emit       (emit),
         .x          (x_d),
         .y          (y_d),
         .z          (z_d)
      );

      assign z_p[gi] = z_d[1];
      assign z_m[gi] = z_d[0];
   end

endmodule
